// File: rtl/i2s_tx.sv
// I2S transmitter: derives BCLK/LRCLK from clk_i, requests one stereo sample per
// frame, and shifts it out MSB-first with the standard one-BCLK I2S data delay.
module i2s_tx #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] sample_i,
  output logic        sample_req_o,
  output logic        bclk_o,
  output logic        lrclk_o,
  output logic        sdata_o
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;
  logic [4:0]    bit_cnt;
  logic [4:0]    bit_nxt;
  logic [31:0]   shift;
  logic [31:0]   hold;
  logic          req_d;
  logic          half_tick;
  logic          fall_tick;

  assign half_tick = (div_cnt == DIV_LAST);
  assign fall_tick = half_tick & bclk_o;
  assign bit_nxt   = bit_cnt + 5'd1;

  // NOTE: every register here is sequential state, so all updates use <=;
  // blocking assignments would let later statements see same-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_cnt      <= '0;
      bclk_o       <= 1'b0;
      bit_cnt      <= 5'd31;
      lrclk_o      <= 1'b0;
      sdata_o      <= 1'b0;
      shift        <= '0;
      hold         <= '0;
      sample_req_o <= 1'b0;
      req_d        <= 1'b0;
    end else begin
      div_cnt      <= half_tick ? '0 : div_cnt + 1'b1;
      sample_req_o <= 1'b0;
      req_d        <= sample_req_o;

      if (half_tick) bclk_o <= ~bclk_o;

      // The producer answers one cycle after the request; capture only then.
      if (req_d) hold <= sample_i;

      if (fall_tick) begin
        bit_cnt <= bit_nxt;
        lrclk_o <= (bit_nxt >= 5'd15) && (bit_nxt <= 5'd30);
        if (bit_nxt == 5'd0) begin
          shift        <= hold << 1;
          sdata_o      <= hold[31];
          sample_req_o <= 1'b1;
        end else begin
          shift   <= shift << 1;
          sdata_o <= shift[31];
        end
      end
    end
  end

endmodule
